// File: rtl/msg_serializer.sv
// Frame serializer: sends a fixed header, a captured payload and an optional
// even-parity bit on a single line, holding each bit for BIT_CYCLES clocks.
module msg_serializer #(
  parameter int                MSG_W      = 5,
  parameter int                HDR_W      = 4,
  parameter logic [HDR_W-1:0]  HDR        = 4'b0101,
  parameter int                BIT_CYCLES = 1024,
  parameter int                PARITY_EN  = 0,
  parameter int                LSB_FIRST  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic [MSG_W-1:0] msg,
  input  logic             abort,
  output logic             msg_bit,
  output logic             busy,
  output logic             done
);

  localparam int FRAME_W = HDR_W + MSG_W + PARITY_EN;
  localparam int CYC_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d, loaded;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic               done_q, done_d;

  // Frame image with index 0 being the first bit on the line; it shifts right.
  always_comb begin
    loaded = '0;
    for (int i = 0; i < HDR_W; i++)
      loaded[i] = HDR[HDR_W-1-i];
    for (int i = 0; i < MSG_W; i++)
      loaded[HDR_W+i] = (LSB_FIRST != 0) ? msg[i] : msg[MSG_W-1-i];
    if (PARITY_EN != 0)
      loaded[FRAME_W-1] = ^msg;
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (send) begin
          state_d   = SEND;
          frame_d   = loaded;
          bit_cnt_d = '0;
          cyc_cnt_d = '0;
        end
      end
      SEND: begin
        // Abort wins over completion, so a cancelled frame never pulses done.
        if (abort) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          cyc_cnt_d = '0;
        end else if (cyc_cnt_q == CYC_LAST) begin
          cyc_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            frame_d   = frame_q >> 1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == SEND);
  assign msg_bit = busy & frame_q[0];
  assign done    = done_q;

endmodule

// File: tb/tb_msg_serializer.sv
// Directed bench for msg_serializer: dut_a uses defaults, dut_b sends LSB first
// with parity; both hold each bit for 4 cycles.
module tb_msg_serializer;

  localparam int BC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       send_a = 1'b0, abort_a = 1'b0;
  logic [4:0] msg_a = '0;
  logic       bit_a, busy_a, done_a;
  logic       send_b = 1'b0, abort_b = 1'b0;
  logic [4:0] msg_b = '0;
  logic       bit_b, busy_b, done_b;

  int n_checks = 0;
  int n_errors = 0;

  // Expected line sequences; bit k is the k-th bit transmitted.
  localparam logic [9:0] SEQ_A = 10'b0011011010; // msg 10110, MSB first
  localparam logic [9:0] SEQ_B = 10'b1001111010; // msg 00111, LSB first + parity
  localparam logic [9:0] SEQ_C = 10'b0101101010; // msg 01101, MSB first
  localparam logic [9:0] SEQ_D = 10'b0001111010; // msg 11100, MSB first

  msg_serializer #(.BIT_CYCLES(BC)) dut_a (
    .clk(clk), .rst(rst), .send(send_a), .msg(msg_a), .abort(abort_a),
    .msg_bit(bit_a), .busy(busy_a), .done(done_a)
  );

  msg_serializer #(.BIT_CYCLES(BC), .PARITY_EN(1), .LSB_FIRST(1)) dut_b (
    .clk(clk), .rst(rst), .send(send_b), .msg(msg_b), .abort(abort_b),
    .msg_bit(bit_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int sel, input logic exp_done, input string tag);
    check({tag, " busy"},    (sel != 0) ? busy_b : busy_a, 32'(1'b0));
    check({tag, " msg_bit"}, (sel != 0) ? bit_b  : bit_a,  32'(1'b0));
    check({tag, " done"},    (sel != 0) ? done_b : done_a, 32'(exp_done));
  endtask

  task automatic check_bits(input int sel, input logic [9:0] seq, input int lo, input int hi,
                            input string tag);
    for (int k = lo; k <= hi; k++) begin
      for (int c = 0; c < BC; c++) begin
        check($sformatf("%s bit%0d c%0d busy", tag, k, c), (sel != 0) ? busy_b : busy_a, 32'(1'b1));
        check($sformatf("%s bit%0d c%0d line", tag, k, c), (sel != 0) ? bit_b : bit_a, 32'(seq[k]));
        check($sformatf("%s bit%0d c%0d done", tag, k, c), (sel != 0) ? done_b : done_a, 32'(1'b0));
        tick();
      end
    end
  endtask

  initial begin
    // Reset state, then no spontaneous frame after release
    tick();
    check_idle(0, 1'b0, "reset_a");
    check_idle(1, 1'b0, "reset_b");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle(0, 1'b0, "post_reset_a");
    end

    // Basic frame, with msg change and send pulses while busy
    msg_a  = 5'b10110;
    send_a = 1'b1;
    tick();
    send_a = 1'b0;
    check_bits(0, SEQ_A, 0, 1, "basic");
    msg_a  = 5'b01001;
    send_a = 1'b1;
    check_bits(0, SEQ_A, 2, 2, "basic");
    send_a = 1'b0;
    check_bits(0, SEQ_A, 3, 8, "basic");
    check_idle(0, 1'b1, "basic_done");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle(0, 1'b0, "basic_after");
    end

    // LSB first with parity
    msg_b  = 5'b00111;
    send_b = 1'b1;
    tick();
    send_b = 1'b0;
    check_bits(1, SEQ_B, 0, 9, "parity");
    check_idle(1, 1'b1, "parity_done");
    tick();
    check_idle(1, 1'b0, "parity_after");

    // send held high: back-to-back frames, msg recaptured
    msg_a  = 5'b10110;
    send_a = 1'b1;
    tick();
    check_bits(0, SEQ_A, 0, 3, "b2b1");
    msg_a = 5'b01101;
    check_bits(0, SEQ_A, 4, 8, "b2b1");
    check_idle(0, 1'b1, "b2b_gap");
    tick();
    check_bits(0, SEQ_C, 0, 8, "b2b2");
    check_idle(0, 1'b1, "b2b2_done");
    send_a = 1'b0;
    tick();
    check_idle(0, 1'b0, "b2b_after");

    // Abort during bit 3
    msg_a  = 5'b10110;
    send_a = 1'b1;
    tick();
    send_a = 1'b0;
    check_bits(0, SEQ_A, 0, 2, "abort");
    abort_a = 1'b1;
    check("abort bit3 busy", busy_a, 32'(1'b1));
    check("abort bit3 line", bit_a, 32'(SEQ_A[3]));
    tick();
    abort_a = 1'b0;
    check_idle(0, 1'b0, "abort_next");
    for (int i = 0; i < 2; i++) begin
      tick();
      check_idle(0, 1'b0, "abort_idle");
    end

    // Abort in IDLE is ignored; abort beats completion on the last edge
    msg_a   = 5'b11100;
    send_a  = 1'b1;
    abort_a = 1'b1;
    tick();
    send_a  = 1'b0;
    abort_a = 1'b0;
    check_bits(0, SEQ_D, 0, 7, "clean");
    for (int c = 0; c < BC - 1; c++) begin
      check("clean bit8 busy", busy_a, 32'(1'b1));
      check("clean bit8 line", bit_a, 32'(SEQ_D[8]));
      tick();
    end
    abort_a = 1'b1;
    check("clean last busy", busy_a, 32'(1'b1));
    tick();
    abort_a = 1'b0;
    check_idle(0, 1'b0, "abort_last");
    tick();
    check_idle(0, 1'b0, "abort_last_after");

    // Asynchronous reset mid-frame, send ignored during reset
    msg_a  = 5'b10110;
    send_a = 1'b1;
    tick();
    send_a = 1'b0;
    check_bits(0, SEQ_A, 0, 0, "arst");
    #2;
    check("arst pre busy", busy_a, 32'(1'b1));
    check("arst pre line", bit_a, 32'(SEQ_A[1]));
    rst = 1'b0;
    #1;
    check_idle(0, 1'b0, "arst_async");
    send_a = 1'b1;
    tick();
    tick();
    check_idle(0, 1'b0, "arst_held");
    send_a = 1'b0;
    rst    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_idle(0, 1'b0, "arst_released");
    end
    msg_a  = 5'b10110;
    send_a = 1'b1;
    tick();
    send_a = 1'b0;
    check_bits(0, SEQ_A, 0, 8, "post_arst");
    check_idle(0, 1'b1, "post_arst_done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
